// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - multi-cycle data-memory responder for the MEM-stage load/store port
// Accepts one request at a time, waits WAIT_CYCLES, performs the access and pulses a response.
module data_memory_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 3,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reqValid,
   input  logic                  reqWrite,
   input  logic [31:0]           reqAddr,
   input  logic [DATA_WIDTH-1:0] reqWriteData,
   output logic                  reqReady,
   output logic                  respValid,
   output logic [DATA_WIDTH-1:0] respReadData,
   output logic                  respError,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESPOND
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [31:0]             addr_q;
   logic                    wr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    err_q;

   logic                    cap_en;
   logic                    access_en;
   logic [31:0]             acc_addr;
   logic                    acc_wr;
   logic [DATA_WIDTH-1:0]   acc_data;
   logic                    acc_in_range;
   logic [ADDR_WIDTH-1:0]   acc_idx;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_en    = 1'b0;
      access_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (reqValid) begin
               cap_en = 1'b1;
               cnt_d  = CW'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  state_d   = S_RESPOND;
                  access_en = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d   = S_RESPOND;
               access_en = 1'b1;
            end
         end
         S_RESPOND: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // With zero wait the access happens on the acceptance edge, so it must use the live request.
   always_comb begin
      acc_addr = addr_q;
      acc_wr   = wr_q;
      acc_data = wdata_q;
      if (state_q == S_IDLE) begin
         acc_addr = reqAddr;
         acc_wr   = reqWrite;
         acc_data = reqWriteData;
      end
   end

   assign acc_in_range = (acc_addr[31:ADDR_WIDTH] == '0);
   assign acc_idx      = acc_addr[ADDR_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= DATA_WIDTH'(i);
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (cap_en) begin
            addr_q  <= reqAddr;
            wr_q    <= reqWrite;
            wdata_q <= reqWriteData;
         end
         if (access_en) begin
            err_q <= !acc_in_range;
            if (!acc_in_range) begin
               rdata_q <= '0;
            end else if (acc_wr) begin
               mem_q[acc_idx] <= acc_data;
               rdata_q        <= '0;
            end else begin
               rdata_q <= mem_q[acc_idx];
            end
         end
      end
   end

   assign reqReady     = (state_q == S_IDLE);
   assign busy         = !reqReady;
   assign respValid    = (state_q == S_RESPOND);
   assign respReadData = rdata_q;
   assign respError    = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed self-checking bench for data_memory_responder
// Covers WAIT_CYCLES=2 (dut) and WAIT_CYCLES=0 (dut0) builds.
module tb_data_memory_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        reqValid = 1'b0, reqWrite = 1'b0;
   logic [31:0] reqAddr = '0, reqWriteData = '0;
   logic        reqReady, respValid, respError, busy;
   logic [31:0] respReadData;

   logic        reqValid0 = 1'b0, reqWrite0 = 1'b0;
   logic [31:0] reqAddr0 = '0, reqWriteData0 = '0;
   logic        reqReady0, respValid0, respError0, busy0;
   logic [31:0] respReadData0;

   int checks = 0;
   int errors = 0;
   int pulses;

   always #5 clk = ~clk;

   data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWriteData(reqWriteData),
      .reqReady(reqReady), .respValid(respValid), .respReadData(respReadData),
      .respError(respError), .busy(busy)
   );

   data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset),
      .reqValid(reqValid0), .reqWrite(reqWrite0), .reqAddr(reqAddr0), .reqWriteData(reqWriteData0),
      .reqReady(reqReady0), .respValid(respValid0), .respReadData(respReadData0),
      .respError(respError0), .busy(busy0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // One complete transaction on the WAIT_CYCLES=2 instance, ending in the following IDLE cycle.
   task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic exp_e, input string tag);
      int n;
      reqValid = 1'b1; reqWrite = w; reqAddr = a; reqWriteData = d;
      n = 0;
      while (!reqReady && n < 20) begin tick(); n++; end
      chk({tag, "_ready"}, 32'(reqReady), 32'd1);
      tick();
      reqValid = 1'b0;
      n = 1;
      while (!respValid && n < 20) begin tick(); n++; end
      chk({tag, "_latency"}, n, 32'd3);
      chk({tag, "_data"}, respReadData, exp_d);
      chk({tag, "_err"}, 32'(respError), 32'(exp_e));
      tick();
      chk({tag, "_valid_drop"}, 32'(respValid), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      tick(); tick();
      chk("rst_ready", 32'(reqReady), 32'd1);
      chk("rst_valid", 32'(respValid), 32'd0);
      chk("rst_data", respReadData, 32'd0);
      chk("rst_err", 32'(respError), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      // 1: basic load
      req(1'b0, 32'd5, 32'd0, 32'd5, 1'b0, "t1_ld5");
      chk("t1_hold", respReadData, 32'd5);

      // 2: store then load back
      req(1'b1, 32'd3, 32'hDEADBEEF, 32'd0, 1'b0, "t2_st3");
      req(1'b0, 32'd3, 32'd0, 32'hDEADBEEF, 1'b0, "t2_ld3");
      req(1'b0, 32'd2, 32'd0, 32'd2, 1'b0, "t2_ld2");

      // 3: out-of-range access
      req(1'b1, 32'd9, 32'hCAFEF00D, 32'd0, 1'b1, "t3_st9");
      req(1'b0, 32'd1, 32'd0, 32'd1, 1'b0, "t3_ld1");
      req(1'b0, 32'd9 & 32'd7, 32'd0, 32'd1, 1'b0, "t3_ld9m");
      req(1'b0, 32'h8000_0002, 32'd0, 32'd0, 1'b1, "t3_ldhi");

      // 4: request held while busy is ignored until IDLE
      reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'd6;
      tick();
      reqAddr = 32'd2;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         chk("t4_not_ready", 32'(reqReady), 32'd0);
         if (respValid) begin
            pulses++;
            chk("t4_data6", respReadData, 32'd6);
         end
         tick();
      end
      chk("t4_ready_again", 32'(reqReady), 32'd1);
      tick();
      reqValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (respValid) begin
            pulses++;
            chk("t4_data2", respReadData, 32'd2);
         end
         tick();
      end
      chk("t4_pulses", pulses, 32'd2);
      chk("t4_idle", 32'(busy), 32'd0);

      // 5: reset during WAIT of a store discards it
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'd4; reqWriteData = 32'h12345678;
      tick();
      reqValid = 1'b0;
      chk("t5_busy", 32'(busy), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_busy_after_rst", 32'(busy), 32'd0);
      chk("t5_no_valid", 32'(respValid), 32'd0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         if (respValid) pulses++;
         tick();
      end
      chk("t5_no_pulse", pulses, 32'd0);
      req(1'b0, 32'd4, 32'd0, 32'd4, 1'b0, "t5_ld4");

      // 6: zero-wait build, back-to-back spacing of 2 cycles
      reqValid0 = 1'b1; reqWrite0 = 1'b0; reqAddr0 = 32'd7;
      chk("t6_ready", 32'(reqReady0), 32'd1);
      tick();
      reqAddr0 = 32'd3;
      chk("t6_valid7", 32'(respValid0), 32'd1);
      chk("t6_data7", respReadData0, 32'd7);
      chk("t6_busy", 32'(busy0), 32'd1);
      tick();
      chk("t6_gap_valid", 32'(respValid0), 32'd0);
      chk("t6_gap_ready", 32'(reqReady0), 32'd1);
      chk("t6_gap_hold", respReadData0, 32'd7);
      tick();
      reqValid0 = 1'b0;
      chk("t6_valid3", 32'(respValid0), 32'd1);
      chk("t6_data3", respReadData0, 32'd3);
      chk("t6_err3", 32'(respError0), 32'd0);
      tick();
      chk("t6_idle", 32'(busy0), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
